interrupt_service_responder: RTL and testbench
==============================================

INTERRUPT_SERVICE_RESPONDER -- requirements
Module: interrupt_service_responder

Interface
REQ-001 The block SHALL have parameter NINTR, default 4, meaning the number of interrupt lines (ack width).
REQ-002 The block SHALL derive localparam VW = $clog2(NINTR), meaning the vector index width.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state is updated on its rising edge.
REQ-004 Port reset_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-005 Port irq, input, 1, SHALL be the interrupt-pending indication from the interrupt controller.
REQ-006 Port ack, input, NINTR, SHALL be the one-hot granted line from the controller, qualified by irq.
REQ-007 Port svc_len, input, 8, SHALL be the service duration in cycles, sampled on entry to SERVICE (0 treated as 1).
REQ-008 Port done, output, 1, SHALL be the registered one-cycle service-complete pulse returned to the controller.
REQ-009 Port vector, output, VW, SHALL be the registered binary index of the interrupt being serviced.
REQ-010 Port busy, output, 1, SHALL be high in any state other than IDLE.
REQ-011 Port err, output, 1, SHALL be the sticky protocol-error flag.
REQ-012 Port svc_count, output, 16, SHALL be the count of completed services, wrapping from 0xFFFF to 0.
REQ-013 Port preempt_count, output, 8, SHALL be the count of preemptions, saturating at 0xFF.

Function
REQ-014 The FSM SHALL have states IDLE, DECODE, SERVICE, DONE and SHALL be one-hot encoded.
REQ-015 IDLE: when irq=1 and ack is exactly one-hot, the FSM SHALL latch vector = bit index of ack and go to DECODE.
REQ-016 IDLE: when irq=1 and ack is zero or multi-hot, the FSM SHALL set err=1 and stay in IDLE.
REQ-017 DECODE SHALL last exactly one cycle, load the down-counter with max(svc_len,1), and go to SERVICE.
REQ-018 SERVICE SHALL decrement the counter each cycle; at the edge where the counter equals 1 it SHALL go to DONE and drive done=1.
REQ-019 Latency: done SHALL rise at edge E0+L+1, where E0 is the IDLE sampling edge and L = max(svc_len,1).
REQ-020 done SHALL be high for exactly one cycle per completed service; svc_count SHALL increment at that same edge.
REQ-021 Preemption: in SERVICE, when irq=1 and ack is one-hot with a different index from vector, the block SHALL latch the new vector, reload the counter with max(svc_len,1), increment preempt_count, and stay in SERVICE.
REQ-022 In SERVICE, a one-hot ack equal to vector SHALL have no effect; a zero or multi-hot ack with irq=1 SHALL set err and be otherwise ignored.
REQ-023 In SERVICE, irq=0 SHALL set err and return the FSM to IDLE without asserting done.
REQ-024 DONE: the FSM SHALL remain in DONE until irq=0 is sampled, then go to IDLE, so that one grant is never serviced twice.
REQ-025 If preemption and counter-expiry coincide on the same edge, preemption SHALL win and done SHALL NOT assert.
REQ-026 err SHALL clear only on reset.

Reset
REQ-027 On reset_n=0 the block SHALL immediately (asynchronously) return to IDLE, including mid-service.
REQ-028 Reset values SHALL be: done=0, vector=0, busy=0, err=0, svc_count=0, preempt_count=0, counter=0.
REQ-029 No done pulse SHALL be produced for a service interrupted by reset.

Verification
REQ-030 irq=1, ack=4'b0100, svc_len=3 at E0 -> vector=2, busy=1; done high only in the cycle after E4; svc_count=1; hold irq=1 for two more cycles -> no second done, idle once irq=0.
REQ-031 svc_len=0 with ack=4'b0001 -> done rises at E2 (treated as 1).
REQ-032 ack=4'b0100 at E0 with svc_len=5, then ack=4'b0001 at E2 -> vector=0, preempt_count=1, done at E2+5+... (counter reloaded at E2, done 5 edges later), svc_count=1.
REQ-033 irq=1 with ack=4'b0110 in IDLE -> err=1, busy stays 0, no done.
REQ-034 irq drops to 0 mid-SERVICE -> err=1, return to IDLE, no done pulse.
REQ-035 reset_n low mid-SERVICE -> all outputs return to reset values at once; after release with irq=0 -> stays IDLE.

Source files
------------

// File: rtl/interrupt_service_responder_if.sv
// Handshake bundle between the interrupt controller (master) and the service responder (slave).
interface interrupt_service_responder_if #(
   parameter int unsigned NINTR = 4
);
   localparam int unsigned VW = $clog2(NINTR);

   logic             irq;
   logic [NINTR-1:0] ack;
   logic [7:0]       svc_len;
   logic             done;
   logic [VW-1:0]    vector;
   logic             busy;
   logic             err;
   logic [15:0]      svc_count;
   logic [7:0]       preempt_count;

   modport master (
      output irq, ack, svc_len,
      input  done, vector, busy, err, svc_count, preempt_count
   );

   modport slave (
      input  irq, ack, svc_len,
      output done, vector, busy, err, svc_count, preempt_count
   );
endinterface

// File: rtl/interrupt_service_responder.sv
// Services one granted interrupt at a time for svc_len cycles, supports preemption by a
// different grant, and reports completion, protocol errors and service/preemption counts.
module interrupt_service_responder #(
   parameter int unsigned NINTR = 4
) (
   input logic                          clk,
   input logic                          reset_n,
   interrupt_service_responder_if.slave bus
);
   localparam int unsigned VW  = $clog2(NINTR);
   localparam int unsigned CW  = 8;
   localparam int unsigned SCW = 16;
   localparam int unsigned PCW = 8;

   typedef enum logic [3:0] {
      S_IDLE    = 4'b0001,
      S_DECODE  = 4'b0010,
      S_SERVICE = 4'b0100,
      S_DONE    = 4'b1000
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [VW-1:0]    r_vector;
   logic             r_done;
   logic             r_busy;
   logic             r_err;
   logic [SCW-1:0]   r_svc_count;
   logic [PCW-1:0]   r_preempt_count;

   logic             w_ack_onehot;
   logic [VW-1:0]    w_ack_idx;
   logic [CW-1:0]    w_load_len;
   logic             w_preempt;

   // Single-bit-set test: nonzero and clearing the lowest set bit leaves nothing.
   assign w_ack_onehot = (bus.ack != '0) && ((bus.ack & (bus.ack - NINTR'(1))) == '0);
   assign w_load_len   = (bus.svc_len == '0) ? CW'(1) : bus.svc_len;
   assign w_preempt    = bus.irq && w_ack_onehot && (w_ack_idx != r_vector);

   // Binary index of the set ack bit; only meaningful when ack is one-hot.
   always_comb begin
      w_ack_idx = '0;
      for (int i = 0; i < int'(NINTR); i++) begin
         if (bus.ack[i]) begin
            w_ack_idx = VW'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state         <= S_IDLE;
         r_cnt           <= '0;
         r_vector        <= '0;
         r_done          <= 1'b0;
         r_busy          <= 1'b0;
         r_err           <= 1'b0;
         r_svc_count     <= '0;
         r_preempt_count <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.irq) begin
                  if (w_ack_onehot) begin
                     r_vector <= w_ack_idx;
                     r_state  <= S_DECODE;
                     r_busy   <= 1'b1;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            S_DECODE: begin
               r_cnt   <= w_load_len;
               r_state <= S_SERVICE;
            end
            S_SERVICE: begin
               // Withdrawn request aborts; preemption outranks a coincident expiry.
               if (!bus.irq) begin
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else if (w_preempt) begin
                  r_vector <= w_ack_idx;
                  r_cnt    <= w_load_len;
                  if (r_preempt_count != {PCW{1'b1}}) begin
                     r_preempt_count <= r_preempt_count + PCW'(1);
                  end
               end else begin
                  if (!w_ack_onehot) begin
                     r_err <= 1'b1;
                  end
                  if (r_cnt == CW'(1)) begin
                     r_done      <= 1'b1;
                     r_svc_count <= r_svc_count + SCW'(1);
                     r_state     <= S_DONE;
                  end
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_DONE: begin
               // Wait for the controller to drop irq so one grant is serviced once.
               if (!bus.irq) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.done          = r_done;
   assign bus.vector        = r_vector;
   assign bus.busy          = r_busy;
   assign bus.err           = r_err;
   assign bus.svc_count     = r_svc_count;
   assign bus.preempt_count = r_preempt_count;
endmodule

// File: tb/tb_interrupt_service_responder.sv
// Directed bench for interrupt_service_responder: an edge-counting reference model is compared
// every cycle, and literal expectations pin the key latencies and counter values.
module tb_interrupt_service_responder;
   localparam int unsigned NINTR = 4;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   interrupt_service_responder_if #(.NINTR(NINTR)) bus ();

   interrupt_service_responder #(.NINTR(NINTR)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: absolute edge numbers instead of a down-counter.
   int          n_edge;
   int          start_edge;
   int          due_edge;
   int          mode;            // 0 idle, 1 decode/service, 2 waiting for irq release
   bit          mvalid;
   logic        exp_done;
   logic [1:0]  exp_vec;
   logic        exp_busy;
   logic        exp_err;
   logic [15:0] exp_sc;
   logic [7:0]  exp_pc;

   function automatic bit is_onehot(input logic [NINTR-1:0] a);
      return $countones(a) == 1;
   endfunction

   function automatic logic [1:0] idx_of(input logic [NINTR-1:0] a);
      logic [1:0] r;
      r = '0;
      for (int i = 0; i < int'(NINTR); i++) if (a[i]) r = 2'(i);
      return r;
   endfunction

   task automatic expect_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         n_edge = 0; start_edge = 0; due_edge = 0; mode = 0; mvalid = 1'b1;
         exp_done = 0; exp_vec = 0; exp_busy = 0; exp_err = 0; exp_sc = 0; exp_pc = 0;
      end else begin
         int len;
         bit oh;
         logic [1:0] ix;
         n_edge++;
         exp_done = 1'b0;
         len = (bus.svc_len == 0) ? 1 : int'(bus.svc_len);
         oh  = is_onehot(bus.ack);
         ix  = idx_of(bus.ack);
         case (mode)
            0: if (bus.irq) begin
                  if (oh) begin mode = 1; exp_vec = ix; start_edge = n_edge; end
                  else exp_err = 1'b1;
               end
            1: if (n_edge == start_edge + 1) begin
                  due_edge = n_edge + len;
               end else if (!bus.irq) begin
                  exp_err = 1'b1; mode = 0;
               end else if (oh && ix != exp_vec) begin
                  exp_vec = ix; due_edge = n_edge + len;
                  if (exp_pc != 8'hFF) exp_pc = exp_pc + 8'd1;
               end else begin
                  if (!oh) exp_err = 1'b1;
                  if (n_edge == due_edge) begin
                     exp_done = 1'b1; exp_sc = exp_sc + 16'd1; mode = 2;
                  end
               end
            default: if (!bus.irq) mode = 0;
         endcase
         exp_busy = (mode != 0);
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (mvalid) begin
         expect_eq("cyc_done",    32'(bus.done),          32'(exp_done));
         expect_eq("cyc_vector",  32'(bus.vector),        32'(exp_vec));
         expect_eq("cyc_busy",    32'(bus.busy),          32'(exp_busy));
         expect_eq("cyc_err",     32'(bus.err),           32'(exp_err));
         expect_eq("cyc_svc",     32'(bus.svc_count),     32'(exp_sc));
         expect_eq("cyc_preempt", 32'(bus.preempt_count), 32'(exp_pc));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic irq_v, input logic [3:0] ack_v, input logic [7:0] len_v);
      bus.irq = irq_v; bus.ack = ack_v; bus.svc_len = len_v;
   endtask

   task automatic expect_reset_values(input string tag);
      expect_eq({tag, "_done"},    32'(bus.done),          32'd0);
      expect_eq({tag, "_vector"},  32'(bus.vector),        32'd0);
      expect_eq({tag, "_busy"},    32'(bus.busy),          32'd0);
      expect_eq({tag, "_err"},     32'(bus.err),           32'd0);
      expect_eq({tag, "_svc"},     32'(bus.svc_count),     32'd0);
      expect_eq({tag, "_preempt"}, 32'(bus.preempt_count), 32'd0);
   endtask

   initial begin
      checks = 0; errors = 0; mvalid = 1'b0;
      reset_n = 1'b0;
      drive(1'b0, 4'b0000, 8'd0);
      repeat (3) tick();
      expect_reset_values("rst");
      reset_n = 1'b1;
      tick();

      // Basic service, svc_len=3, grant held two cycles past done.
      drive(1'b1, 4'b0100, 8'd3);
      tick();
      expect_eq("b_vector", 32'(bus.vector), 32'd2);
      expect_eq("b_busy",   32'(bus.busy),   32'd1);
      repeat (3) tick();
      expect_eq("b_done_early", 32'(bus.done), 32'd0);
      tick();
      expect_eq("b_done_e4", 32'(bus.done),      32'd1);
      expect_eq("b_svc",     32'(bus.svc_count), 32'd1);
      repeat (2) tick();
      expect_eq("b_no_second_done", 32'(bus.done), 32'd0);
      expect_eq("b_busy_hold",      32'(bus.busy), 32'd1);
      drive(1'b0, 4'b0000, 8'd3);
      tick();
      expect_eq("b_idle", 32'(bus.busy), 32'd0);

      // svc_len=0 behaves as 1.
      drive(1'b1, 4'b0001, 8'd0);
      repeat (2) tick();
      expect_eq("z_done_e1", 32'(bus.done), 32'd0);
      tick();
      expect_eq("z_done_e2", 32'(bus.done),      32'd1);
      expect_eq("z_svc",     32'(bus.svc_count), 32'd2);
      drive(1'b0, 4'b0000, 8'd0);
      tick();

      // Preemption at E2 reloads the counter; done 5 edges later.
      drive(1'b1, 4'b0100, 8'd5);
      repeat (2) tick();
      bus.ack = 4'b0001;
      tick();
      expect_eq("p_vector",  32'(bus.vector),        32'd0);
      expect_eq("p_preempt", 32'(bus.preempt_count), 32'd1);
      repeat (4) tick();
      expect_eq("p_done_early", 32'(bus.done), 32'd0);
      tick();
      expect_eq("p_done", 32'(bus.done),      32'd1);
      expect_eq("p_svc",  32'(bus.svc_count), 32'd3);
      expect_eq("p_err",  32'(bus.err),       32'd0);
      drive(1'b0, 4'b0000, 8'd5);
      tick();

      // Multi-hot grant in IDLE.
      drive(1'b1, 4'b0110, 8'd2);
      tick();
      expect_eq("m_err",  32'(bus.err),  32'd1);
      expect_eq("m_busy", 32'(bus.busy), 32'd0);
      expect_eq("m_done", 32'(bus.done), 32'd0);
      drive(1'b0, 4'b0000, 8'd2);
      tick();
      reset_n = 1'b0;
      tick();
      expect_eq("m_err_cleared", 32'(bus.err), 32'd0);
      reset_n = 1'b1;
      tick();

      // irq withdrawn mid-service.
      drive(1'b1, 4'b0010, 8'd8);
      repeat (3) tick();
      drive(1'b0, 4'b0000, 8'd8);
      tick();
      expect_eq("a_err",  32'(bus.err),  32'd1);
      expect_eq("a_busy", 32'(bus.busy), 32'd0);
      repeat (8) tick();
      expect_eq("a_svc", 32'(bus.svc_count), 32'd0);

      // Asynchronous reset mid-service.
      drive(1'b1, 4'b0100, 8'd6);
      repeat (3) tick();
      reset_n = 1'b0;
      #1;
      expect_reset_values("ar");
      drive(1'b0, 4'b0000, 8'd6);
      tick();
      reset_n = 1'b1;
      repeat (3) tick();
      expect_eq("ar_idle_busy", 32'(bus.busy), 32'd0);
      expect_eq("ar_idle_done", 32'(bus.done), 32'd0);

      // Preemption coinciding with expiry wins.
      drive(1'b1, 4'b0001, 8'd1);
      repeat (2) tick();
      bus.ack = 4'b0010;
      tick();
      expect_eq("c_done",    32'(bus.done),          32'd0);
      expect_eq("c_vector",  32'(bus.vector),        32'd1);
      expect_eq("c_preempt", 32'(bus.preempt_count), 32'd1);
      tick();
      expect_eq("c_done_late", 32'(bus.done),      32'd1);
      expect_eq("c_svc",       32'(bus.svc_count), 32'd1);
      drive(1'b0, 4'b0000, 8'd1);
      tick();

      // Preemption counter saturation.
      drive(1'b1, 4'b0001, 8'd200);
      repeat (2) tick();
      for (int i = 0; i < 260; i++) begin
         bus.ack = (i % 2 == 0) ? 4'b0010 : 4'b0001;
         tick();
      end
      expect_eq("s_preempt", 32'(bus.preempt_count), 32'd255);
      drive(1'b0, 4'b0000, 8'd200);
      tick();
      expect_eq("s_busy", 32'(bus.busy), 32'd0);
      expect_eq("s_err",  32'(bus.err),  32'd1);

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
